// File: rtl/sync_pkg.sv
// Shared types and helpers for the camera/video sync supervisor.
package sync_pkg;

    typedef enum logic [1:0] {
        RESET_PULSE,
        ACQUIRE,
        TRACK
    } sup_state_t;

    localparam int ABS_W = 64;

    function automatic logic [ABS_W-1:0] abs_signed(input logic signed [ABS_W-1:0] v);
        return v[ABS_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/rise_det.sv
// Registered-history rising-edge detector; history resets high so a level
// already asserted at reset release is not reported as an edge.
module rise_det (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) d_q <= 1'b1;
        else       d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/sync_supervisor.sv
// Measures camera-to-generated vsync phase each frame and drives the timing
// generator reset to acquire and hold lock.
module sync_supervisor
    import sync_pkg::*;
#(
    parameter int RST_CYC     = 16,
    parameter int EXP_OFF     = 0,
    parameter int TOL         = 8,
    parameter int LOCK_FRAMES = 2,
    parameter int BAD_FRAMES  = 3,
    parameter int ACQ_FRAMES  = 4,
    parameter int MEAS_W      = 24,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     force_resync,
    input  logic                     cam_vsync,
    input  logic                     gen_vsync,
    output logic                     gen_rstn,
    output logic                     locked,
    output logic                     meas_valid,
    output logic                     meas_bad,
    output logic signed [MEAS_W:0]   phase_err,
    output logic [CNT_W-1:0]         resync_cnt
);

    localparam logic [MEAS_W-1:0]        MEAS_MAX = '1;
    localparam logic [MEAS_W-1:0]        MEAS_ONE = MEAS_W'(1);
    localparam logic signed [MEAS_W:0]   EXP_S    = (MEAS_W+1)'(EXP_OFF);
    localparam logic [15:0]              RST_LAST = 16'(RST_CYC - 1);
    localparam logic [7:0]               LOCK_N   = 8'(LOCK_FRAMES);
    localparam logic [7:0]               BAD_N    = 8'(BAD_FRAMES);
    localparam logic [7:0]               ACQ_N    = 8'(ACQ_FRAMES);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
        return (v == lim) ? v : v + 8'd1;
    endfunction

    logic                   cam_rise, gen_rise;
    logic                   win_open;
    logic [MEAS_W-1:0]      meas_cnt;
    logic [MEAS_W-1:0]      result;
    logic signed [MEAS_W:0] err;
    logic                   meas_done, meas_lost, judged_bad;
    logic                   frame_good, frame_bad;
    logic                   auto_trig, enter_rp;
    sup_state_t             state;
    logic [15:0]            rst_cnt;
    logic [7:0]             good_cnt, bad_cnt, acq_cnt;

    rise_det u_cam_rise (.clk(clk), .rstn(rstn), .d(cam_vsync), .rise(cam_rise));
    rise_det u_gen_rise (.clk(clk), .rstn(rstn), .d(gen_vsync), .rise(gen_rise));

    // A gen edge in the same cycle as a cam edge is a zero-length measurement.
    always_comb begin
        meas_done = 1'b0;
        meas_lost = 1'b0;
        result    = meas_cnt;
        if (cam_rise && gen_rise) begin
            meas_done = 1'b1;
            result    = '0;
        end else if (gen_rise && win_open) begin
            meas_done = 1'b1;
        end else if (win_open && (cam_rise || meas_cnt == MEAS_MAX)) begin
            meas_lost = 1'b1;
        end
    end

    assign err        = $signed({1'b0, result}) - EXP_S;
    assign judged_bad = abs_signed(64'(err)) > 64'(TOL);
    assign frame_good = meas_done && !judged_bad;
    assign frame_bad  = (meas_done && judged_bad) || meas_lost;

    // meas_cnt holds the elapsed cycles since the opening cam edge, so it is
    // loaded with 1 for the cycle after that edge.
    always_ff @(posedge clk) begin
        if (cam_rise)                              meas_cnt <= MEAS_ONE;
        else if (win_open && meas_cnt != MEAS_MAX) meas_cnt <= meas_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            win_open   <= 1'b0;
            meas_valid <= 1'b0;
            meas_bad   <= 1'b0;
            phase_err  <= '0;
        end else begin
            meas_valid <= (meas_done || meas_lost) && !enter_rp;
            meas_bad   <= frame_bad && !enter_rp;
            if (meas_done && !enter_rp) phase_err <= err;
            if (enter_rp)                     win_open <= 1'b0;
            else if (cam_rise && !gen_rise)   win_open <= 1'b1;
            else if (meas_done || meas_lost)  win_open <= 1'b0;
        end
    end

    always_comb begin
        auto_trig = 1'b0;
        if (en) begin
            case (state)
                ACQUIRE: auto_trig = (good_cnt != LOCK_N) && (acq_cnt == ACQ_N);
                TRACK:   auto_trig = (bad_cnt == BAD_N);
                default: auto_trig = 1'b0;
            endcase
        end
    end

    assign enter_rp = force_resync || auto_trig;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= RESET_PULSE;
            rst_cnt    <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            acq_cnt    <= '0;
            gen_rstn   <= 1'b0;
            locked     <= 1'b0;
            resync_cnt <= '0;
        end else if (enter_rp) begin
            state    <= RESET_PULSE;
            rst_cnt  <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            acq_cnt  <= '0;
            gen_rstn <= 1'b0;
            locked   <= 1'b0;
            if (resync_cnt != '1) resync_cnt <= resync_cnt + 1'b1;
        end else begin
            case (state)
                RESET_PULSE: begin
                    if (rst_cnt == RST_LAST) begin
                        state    <= ACQUIRE;
                        gen_rstn <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 16'd1;
                    end
                end
                ACQUIRE: begin
                    if (good_cnt == LOCK_N) begin
                        state   <= TRACK;
                        locked  <= 1'b1;
                        bad_cnt <= '0;
                    end else begin
                        if (frame_good)     good_cnt <= sat_inc8(good_cnt, LOCK_N);
                        else if (frame_bad) good_cnt <= '0;
                        if (cam_rise)       acq_cnt  <= sat_inc8(acq_cnt, ACQ_N);
                    end
                end
                TRACK: begin
                    if (frame_good)     bad_cnt <= '0;
                    else if (frame_bad) bad_cnt <= sat_inc8(bad_cnt, BAD_N);
                end
                default: state <= RESET_PULSE;
            endcase
        end
    end

endmodule
